// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector with fill-tracking FSM and saturating match counter
module seq_detect_fsm #(
    parameter int W = 4,
    parameter logic [W-1:0] PATTERN = 4'b1011,
    parameter int OVERLAP = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic [W-1:0]     shift_q,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
);
    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FULL = FW'(W);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
    state_t state_q, state_d;
    logic [W-1:0] shift_d, nxt;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic match_q, hit;
    always_comb begin
        nxt = {shift_q[W-2:0], din};
        hit = en && (nxt == PATTERN) && (fill_q >= FULL - FW'(1));
        fill_inc = (fill_q >= FULL) ? FULL : fill_q + FW'(1);
        fill_d = !en ? fill_q : (hit && OVERLAP == 0) ? '0 : fill_inc;
        shift_d = en ? nxt : shift_q;
        count_d = clr ? '0 : (hit && count_q != '1) ? count_q + CNT_W'(1) : count_q;
        state_d = (fill_d == '0) ? IDLE : (fill_d == FULL) ? ARMED : FILL;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
            match_q <= hit;
            count_q <= count_d;
            state_q <= state_d;
        end
    end
    assign match = match_q;
    assign match_count = count_q;
    assign state = state_q;
endmodule
